// File: rtl/bitwise_bist.sv
// BIST sequencer for the 16-bit AND/OR/XOR units: LFSR operands, capture, compare, error log.
// Optional MISR signature enabled by defining BITWISE_BIST_SIGNATURE_EN.
module bitwise_bist #(
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [15:0] SEED_A      = 16'hACE1,
   parameter logic [15:0] SEED_B      = 16'h1D0F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   input  logic [15:0] and_in,
   input  logic [15:0] or_in,
   input  logic [15:0] xor_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] first_fail_idx,
   output logic        fail_valid,
   output logic [15:0] signature
);

   localparam logic [15:0] SEED_A_EFF = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
   localparam logic [15:0] SEED_B_EFF = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;
   localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t      state, state_next;
   logic        start_q;
   logic        launch;
   logic [15:0] vec_idx;
   logic        cap_valid;
   logic [15:0] and_cap, or_cap, xor_cap;
   logic [15:0] and_exp, or_exp, xor_exp;
   logic [15:0] cap_idx;
   logic        mismatch;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   // start is registered so a request seen at one edge launches RUN on the next;
   // requests arriving while busy are dropped rather than queued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         start_q <= 1'b0;
      end else begin
         state   <= state_next;
         start_q <= start && ((state == IDLE) || (state == DONE));
      end
   end

   always_comb begin
      state_next = state;
      launch     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start_q) begin
               state_next = RUN;
               launch     = 1'b1;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (vec_idx == LAST_IDX) state_next = DRAIN;
         end
         DRAIN: begin
            busy       = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start_q) begin
               state_next = RUN;
               launch     = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign pass     = done && (err_count == 16'h0000);
   assign mismatch = (and_cap != and_exp) || (or_cap != or_exp) || (xor_cap != xor_exp);

   // Operands stop advancing on the last vector so they stay visible through DRAIN/DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a           <= 16'h0000;
         op_b           <= 16'h0000;
         vec_idx        <= 16'h0000;
         cap_valid      <= 1'b0;
         and_cap        <= 16'h0000;
         or_cap         <= 16'h0000;
         xor_cap        <= 16'h0000;
         and_exp        <= 16'h0000;
         or_exp         <= 16'h0000;
         xor_exp        <= 16'h0000;
         cap_idx        <= 16'h0000;
         err_count      <= 16'h0000;
         first_fail_idx <= 16'h0000;
         fail_valid     <= 1'b0;
      end else begin
         cap_valid <= (state == RUN);
         if (state == RUN) begin
            and_cap <= and_in;
            or_cap  <= or_in;
            xor_cap <= xor_in;
            and_exp <= op_a & op_b;
            or_exp  <= op_a | op_b;
            xor_exp <= op_a ^ op_b;
            cap_idx <= vec_idx;
         end
         if (launch) begin
            op_a           <= SEED_A_EFF;
            op_b           <= SEED_B_EFF;
            vec_idx        <= 16'h0000;
            err_count      <= 16'h0000;
            first_fail_idx <= 16'h0000;
            fail_valid     <= 1'b0;
         end else begin
            if ((state == RUN) && (vec_idx != LAST_IDX)) begin
               op_a    <= lfsr_step(op_a);
               op_b    <= lfsr_step(op_b);
               vec_idx <= vec_idx + 16'd1;
            end
            if (cap_valid && mismatch) begin
               if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
               if (!fail_valid) begin
                  fail_valid     <= 1'b1;
                  first_fail_idx <= cap_idx;
               end
            end
         end
      end
   end

`ifdef BITWISE_BIST_SIGNATURE_EN
   logic [15:0] sig;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= 16'h0000;
      end else if (launch) begin
         sig <= 16'h0000;
      end else if (cap_valid) begin
         sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h002D : 16'h0000) ^ and_cap
                ^ {or_cap[7:0], or_cap[15:8]} ^ ~xor_cap;
      end
   end

   assign signature = sig;
`else
   assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_bitwise_bist.sv
// Directed bench for bitwise_bist (default build, signature disabled): two instances,
// one with N=4 default seeds, one with N=8 and SEED_A=0 plus fault-injecting unit models.
module tb_bitwise_bist;

   logic        clk;
   logic        rst;
   logic        start_a, start_b;
   logic        b_force_and, b_flip;
   int          tests_run, tests_failed;

   logic [15:0] a_op_a, a_op_b, a_and, a_or, a_xor, a_err, a_first, a_sig;
   logic        a_busy, a_done, a_pass, a_fail_valid;
   logic [15:0] b_op_a, b_op_b, b_and, b_or, b_xor, b_err, b_first, b_sig;
   logic        b_busy, b_done, b_pass, b_fail_valid;

   logic [15:0] va [0:7];
   logic [15:0] vb [0:7];
   logic [15:0] vz [0:7];
   int          and_forced_errs;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unit models: A is fault-free; B can corrupt AND (stuck 0xFFFF) or XOR bit 0.
   assign a_and = a_op_a & a_op_b;
   assign a_or  = a_op_a | a_op_b;
   assign a_xor = a_op_a ^ a_op_b;
   assign b_and = b_force_and ? 16'hFFFF : (b_op_a & b_op_b);
   assign b_or  = b_op_a | b_op_b;
   assign b_xor = (b_op_a ^ b_op_b) ^ {15'd0, b_flip};

   bitwise_bist #(.NUM_VECTORS(4), .SEED_A(16'hACE1), .SEED_B(16'h1D0F)) u_a (
      .clk(clk), .rst(rst), .start(start_a),
      .op_a(a_op_a), .op_b(a_op_b),
      .and_in(a_and), .or_in(a_or), .xor_in(a_xor),
      .busy(a_busy), .done(a_done), .pass(a_pass),
      .err_count(a_err), .first_fail_idx(a_first), .fail_valid(a_fail_valid),
      .signature(a_sig)
   );

   bitwise_bist #(.NUM_VECTORS(8), .SEED_A(16'h0000), .SEED_B(16'h1D0F)) u_b (
      .clk(clk), .rst(rst), .start(start_b),
      .op_a(b_op_a), .op_b(b_op_b),
      .and_in(b_and), .or_in(b_or), .xor_in(b_xor),
      .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_count(b_err), .first_fail_idx(b_first), .fail_valid(b_fail_valid),
      .signature(b_sig)
   );

   function automatic logic [15:0] lfsr_model(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   task automatic check_output(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Returns just after edge E0 (the edge that samples start).
   task automatic apply_start_a();
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic apply_start_b();
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      start_a      = 1'b0;
      start_b      = 1'b0;
      b_force_and  = 1'b0;
      b_flip       = 1'b0;

      va[0] = 16'hACE1;
      vb[0] = 16'h1D0F;
      vz[0] = 16'h0001;
      for (int i = 1; i < 8; i++) begin
         va[i] = lfsr_model(va[i-1]);
         vb[i] = lfsr_model(vb[i-1]);
         vz[i] = lfsr_model(vz[i-1]);
      end
      and_forced_errs = 0;
      for (int i = 0; i < 8; i++)
         if ((vz[i] & vb[i]) != 16'hFFFF) and_forced_errs++;

      repeat (2) @(negedge clk);
      check_output("reset_busy", {15'd0, a_busy}, 16'd0);
      check_output("reset_done", {15'd0, a_done}, 16'd0);
      check_output("reset_pass", {15'd0, a_pass}, 16'd0);
      check_output("reset_op_a", a_op_a, 16'h0000);
      check_output("reset_err", a_err, 16'h0000);
      check_output("reset_fail_valid", {15'd0, a_fail_valid}, 16'd0);
      rst = 1'b0;

      // Clean N=4 run: timing and operand trace.
      apply_start_a();
      check_output("busy_at_E0", {15'd0, a_busy}, 16'd0);
      @(negedge clk);
      check_output("busy_at_E1", {15'd0, a_busy}, 16'd1);
      check_output("vec0_op_a", a_op_a, 16'hACE1);
      check_output("vec0_op_b", a_op_b, 16'h1D0F);
      @(negedge clk);
      check_output("vec1_op_a", a_op_a, 16'h5670);
      check_output("vec1_op_b", a_op_b, vb[1]);
      repeat (3) @(negedge clk);
      check_output("busy_at_E5", {15'd0, a_busy}, 16'd1);
      check_output("done_at_E5", {15'd0, a_done}, 16'd0);
      @(negedge clk);
      check_output("done_at_E6", {15'd0, a_done}, 16'd1);
      check_output("busy_at_E6", {15'd0, a_busy}, 16'd0);
      check_output("clean_pass", {15'd0, a_pass}, 16'd1);
      check_output("clean_err", a_err, 16'h0000);
      check_output("clean_fail_valid", {15'd0, a_fail_valid}, 16'd0);
      check_output("held_op_a", a_op_a, va[3]);
      check_output("clean_signature", a_sig, 16'h0000);
      @(negedge clk);
      check_output("done_holds", {15'd0, a_done}, 16'd1);

      // Reset while vector 3 is on the operands.
      apply_start_a();
      repeat (4) @(negedge clk);
      check_output("vec3_before_rst", a_op_a, va[3]);
      rst = 1'b1;
      #1;
      check_output("midrst_busy", {15'd0, a_busy}, 16'd0);
      check_output("midrst_op_a", a_op_a, 16'h0000);
      check_output("midrst_op_b", a_op_b, 16'h0000);
      check_output("midrst_done", {15'd0, a_done}, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // Fresh run; a start pulse in the middle must not disturb it.
      apply_start_a();
      @(negedge clk);
      check_output("fresh_vec0", a_op_a, 16'hACE1);
      check_output("fresh_err", a_err, 16'h0000);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      check_output("ign_done_E5", {15'd0, a_done}, 16'd0);
      @(negedge clk);
      check_output("ign_done_E6", {15'd0, a_done}, 16'd1);
      check_output("ign_err", a_err, 16'h0000);
      @(negedge clk);
      check_output("ign_no_restart", {15'd0, a_busy}, 16'd0);

      // N=8, zero seed, XOR bit 0 flipped only during vector 2.
      apply_start_b();
      @(negedge clk);
      check_output("zero_seed_op_a", b_op_a, 16'h0001);
      check_output("sig_run_b", b_sig, 16'h0000);
      repeat (2) @(negedge clk);
      check_output("b_vec2_op_a", b_op_a, vz[2]);
      b_flip = 1'b1;
      @(negedge clk);
      b_flip = 1'b0;
      check_output("xor_err_before", b_err, 16'h0000);
      @(negedge clk);
      check_output("xor_err_at_E5", b_err, 16'h0001);
      check_output("xor_fv_at_E5", {15'd0, b_fail_valid}, 16'd1);
      repeat (5) @(negedge clk);
      check_output("xor_done", {15'd0, b_done}, 16'd1);
      check_output("xor_err_final", b_err, 16'h0001);
      check_output("xor_first_idx", b_first, 16'h0002);
      check_output("xor_fail_valid", {15'd0, b_fail_valid}, 16'd1);
      check_output("xor_pass", {15'd0, b_pass}, 16'd0);
      check_output("sig_done_b", b_sig, 16'h0000);

      // N=8 with AND stuck at 0xFFFF for the whole run.
      b_force_and = 1'b1;
      apply_start_b();
      @(negedge clk);
      check_output("rerun_err_cleared", b_err, 16'h0000);
      check_output("rerun_fv_cleared", {15'd0, b_fail_valid}, 16'd0);
      repeat (9) @(negedge clk);
      check_output("and_done", {15'd0, b_done}, 16'd1);
      check_output("and_err", b_err, 16'(and_forced_errs));
      check_output("and_first_idx", b_first, 16'h0000);
      check_output("and_fail_valid", {15'd0, b_fail_valid}, 16'd1);
      check_output("and_pass", {15'd0, b_pass}, 16'd0);
      b_force_and = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bitwise_bist.md
# bitwise_bist

Built-in self-test sequencer for the 16-bit bitwise logic units (BIT_AND, BIT_OR, BIT_XOR).
- Generates pseudo-random signed 16-bit operand pairs, drives them to the three units, and captures their results.
- Checks each result against an internally computed expected value and reports error count, first failing vector index and pass/fail.
- Sits beside the logic units in the processor datapath: this block drives the units' inputs and checks their outputs.

## Interface
- NUM_VECTORS, 256, vectors per run; legal range 1..65535.
- SEED_A, 16'hACE1, LFSR A seed; a zero value is replaced by 16'h0001.
- SEED_B, 16'h1D0F, LFSR B seed; a zero value is replaced by 16'h0001.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled run request; honoured only in IDLE or DONE.
- op_a  out  16  signed operand in1 to the logic units.
- op_b  out  16  signed operand in2 to the logic units.
- and_in / or_in / xor_in  in  16 each  results returned by the units; combinational from op_a/op_b.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  16  count of mismatching vectors; saturates at 16'hFFFF.
- first_fail_idx  out  16  index of the first mismatching vector.
- fail_valid  out  1  first_fail_idx is meaningful.
- signature  out  16  MISR signature of captured results (see Configuration).

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN, or DONE→RUN, on start=1.
  - RUN→DRAIN after NUM_VECTORS cycles in RUN.
  - DRAIN→DONE after 1 cycle.
  - DONE holds until start=1.
- On entry to RUN:
  - op_a=SEED_A, op_b=SEED_B (after zero substitution).
  - err_count, fail_valid, first_fail_idx and signature cleared; vector index cleared to 0.
- Each RUN cycle presents vector k. Both operands then advance by one LFSR step.
- LFSR step (both operands): 16-bit Fibonacci with taps 16,14,13,11. new = {s[0]^s[2]^s[3]^s[5], s[15:1]}. Example: 16'hACE1 → 16'h5670.
- Capture: at the edge ending vector k's cycle, register and_in/or_in/xor_in, the expected values op_a&op_b, op_a|op_b, op_a^op_b, and k.
- Compare: a vector mismatches if any captured result differs from its expected value.
  - On the next edge, err_count increments, saturating at 16'hFFFF.
  - On the first mismatch only, first_fail_idx←k and fail_valid←1.
- start while busy is ignored.
- op_a/op_b hold the last vector through DRAIN and DONE.
- Reset values (rst high, any state, including mid-run):
  - state IDLE.
  - op_a, op_b, err_count, first_fail_idx, signature = 0.
  - busy, done, pass, fail_valid = 0.
  - Capture registers discarded.

## Timing
- start sampled at edge E0 → RUN from E1.
- Vector k (0-based) is presented after edge E(k+1) and captured at E(k+2). Its error update lands at E(k+3).
- Last vector is captured at E(N+1), where N=NUM_VECTORS; DRAIN is entered at the same edge.
- At E(N+2): DONE is entered, done=1, and the final err_count/signature are visible in the same cycle. Total start-to-done = N+2 cycles.
- pass is valid only while done=1.
- Throughput: one vector per clock.

## Configuration
- BITWISE_BIST_SIGNATURE_EN defined:
  - On each compare cycle: sig ← {sig[14:0],1'b0} ^ (sig[15] ? 16'h002D : 0) ^ and_cap ^ {or_cap[7:0],or_cap[15:8]} ^ ~xor_cap.
  - Signature is cleared on RUN entry and frozen in DONE.
- Not defined: signature tied to 16'h0000; no MISR logic.
- All other behaviour is identical in both builds.

## Test plan
- NUM_VECTORS=4 with correct unit models; start pulsed at E0 → busy E1..E5, done=1 at E6, err_count=0, pass=1, fail_valid=0.
- NUM_VECTORS=4; op_a trace → vector 0 = 16'hACE1, vector 1 = 16'h5670; op_b vector 0 = 16'h1D0F.
- NUM_VECTORS=8; bench corrupts xor_in (bit 0 flipped) only while vector 2 is presented → err_count=1, first_fail_idx=2, fail_valid=1, pass=0.
- NUM_VECTORS=8; and_in forced to 16'hFFFF throughout → err_count equals the number of vectors with (a&b)!=16'hFFFF. fail_valid=1 and first_fail_idx=0.
- rst asserted during RUN at vector 3 → all outputs return to 0 immediately. A new start produces a full fresh run with err_count starting at 0; start pulses during RUN are ignored (done still at start+N+2).
- SEED_A=0 → op_a vector 0 = 16'h0001. With BITWISE_BIST_SIGNATURE_EN undefined, signature stays 16'h0000 through the run.
